bram_port_arbiter: RTL and testbench



---
 rtl/bram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of a single BRAM port: round-robin or fixed priority,
// bounded bus locking for atomic sequences, and a one-deep response tag matching BRAM latency.
module bram_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_LOCK_CYCLES = 16,
    parameter int FIXED_PRIORITY  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_m0_valid,
    input  logic [DATA_WIDTH-1:0] i_m0_byte_address,
    input  logic [DATA_WIDTH-1:0] i_m0_write_data,
    input  logic                  i_m0_write_enable,
    input  logic                  i_m0_lock,
    output logic                  o_m0_ready,
    output logic                  o_m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_m0_rsp_data,
    input  logic                  i_m1_valid,
    input  logic [DATA_WIDTH-1:0] i_m1_byte_address,
    input  logic [DATA_WIDTH-1:0] i_m1_write_data,
    input  logic                  i_m1_write_enable,
    input  logic                  i_m1_lock,
    output logic                  o_m1_ready,
    output logic                  o_m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_m1_rsp_data,
    output logic                  o_mem_enable,
    output logic [DATA_WIDTH-1:0] o_mem_byte_address,
    output logic [DATA_WIDTH-1:0] o_mem_write_data,
    output logic                  o_mem_write_enable,
    input  logic [DATA_WIDTH-1:0] i_mem_read_data,
    output logic                  o_lock_timeout
);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK_CYCLES - 1);

    state_t     state, state_nxt;
    logic       ptr, ptr_nxt;
    logic [7:0] lock_cnt, lock_cnt_nxt;
    logic       tag_valid, tag_id;
    logic       grant0, grant1;
    logic       accept0, accept1;
    logic       owner_accept, owner_lock, timeout;

    // Grants already include valid, so ready is never raised for an idle requester.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            ARB: begin
                grant0 = i_m0_valid & (~i_m1_valid | (FIXED_PRIORITY != 0) | ~ptr);
                grant1 = i_m1_valid & ~grant0;
            end
            LOCK0:   grant0 = i_m0_valid;
            LOCK1:   grant1 = i_m1_valid;
            default: ;
        endcase
    end

    assign o_m0_ready = grant0 & ~i_rst;
    assign o_m1_ready = grant1 & ~i_rst;
    assign accept0    = i_m0_valid & o_m0_ready;
    assign accept1    = i_m1_valid & o_m1_ready;

    assign o_mem_enable       = accept0 | accept1;
    assign o_mem_byte_address = accept0 ? i_m0_byte_address :
                                accept1 ? i_m1_byte_address : '0;
    assign o_mem_write_data   = accept0 ? i_m0_write_data :
                                accept1 ? i_m1_write_data : '0;
    assign o_mem_write_enable = accept0 ? i_m0_write_enable :
                                accept1 ? i_m1_write_enable : 1'b0;

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        lock_cnt_nxt = lock_cnt;
        timeout      = 1'b0;
        owner_accept = (state == LOCK1) ? accept1 : accept0;
        owner_lock   = (state == LOCK1) ? i_m1_lock : i_m0_lock;
        case (state)
            ARB: begin
                if (accept0) begin
                    ptr_nxt = 1'b1;
                    if (i_m0_lock) begin
                        state_nxt    = LOCK0;
                        lock_cnt_nxt = '0;
                    end
                end else if (accept1) begin
                    ptr_nxt = 1'b0;
                    if (i_m1_lock) begin
                        state_nxt    = LOCK1;
                        lock_cnt_nxt = '0;
                    end
                end
            end
            LOCK0, LOCK1: begin
                // A request accepted in the final lock cycle still completes; the lock ends anyway.
                if (owner_accept & ~owner_lock) begin
                    state_nxt = ARB;
                    ptr_nxt   = (state == LOCK0);
                end else if (lock_cnt == LOCK_LAST) begin
                    state_nxt = ARB;
                    ptr_nxt   = (state == LOCK0);
                    timeout   = 1'b1;
                end else begin
                    lock_cnt_nxt = lock_cnt + 8'd1;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    assign o_lock_timeout = timeout & ~i_rst;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ARB;
            ptr       <= 1'b0;
            lock_cnt  <= '0;
            tag_valid <= 1'b0;
            tag_id    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            lock_cnt  <= lock_cnt_nxt;
            tag_valid <= accept0 | accept1;
            tag_id    <= accept1;
        end
    end

    assign o_m0_rsp_valid = tag_valid & ~tag_id;
    assign o_m1_rsp_valid = tag_valid & tag_id;
    assign o_m0_rsp_data  = o_m0_rsp_valid ? i_mem_read_data : '0;
    assign o_m1_rsp_data  = o_m1_rsp_valid ? i_mem_read_data : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of grant, lock and response behaviour.
module tb_bram_port_arbiter;

    localparam int DW   = 32;
    localparam int MAXL = 4;
    localparam int FP   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          m0_valid, m0_we, m0_lock, m1_valid, m1_we, m1_lock;
    logic [DW-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic          m0_ready, m0_rsp_valid, m1_ready, m1_rsp_valid;
    logic [DW-1:0] m0_rsp_data, m1_rsp_data;
    logic          mem_enable, mem_we, lock_timeout;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

    logic          f_v0, f_v1, f_ready0, f_ready1, f_rsp_v0, f_rsp_v1, f_mem_en, f_mem_we, f_to;
    logic [DW-1:0] f_rsp_d0, f_rsp_d1, f_mem_addr, f_mem_wdata;

    int checks = 0;
    int passes = 0;

    bram_port_arbiter #(.DATA_WIDTH(DW), .MAX_LOCK_CYCLES(MAXL), .FIXED_PRIORITY(FP)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_valid(m0_valid), .i_m0_byte_address(m0_addr), .i_m0_write_data(m0_wdata),
        .i_m0_write_enable(m0_we), .i_m0_lock(m0_lock), .o_m0_ready(m0_ready),
        .o_m0_rsp_valid(m0_rsp_valid), .o_m0_rsp_data(m0_rsp_data),
        .i_m1_valid(m1_valid), .i_m1_byte_address(m1_addr), .i_m1_write_data(m1_wdata),
        .i_m1_write_enable(m1_we), .i_m1_lock(m1_lock), .o_m1_ready(m1_ready),
        .o_m1_rsp_valid(m1_rsp_valid), .o_m1_rsp_data(m1_rsp_data),
        .o_mem_enable(mem_enable), .o_mem_byte_address(mem_addr), .o_mem_write_data(mem_wdata),
        .o_mem_write_enable(mem_we), .i_mem_read_data(mem_rdata), .o_lock_timeout(lock_timeout)
    );

    bram_port_arbiter #(.DATA_WIDTH(DW), .MAX_LOCK_CYCLES(MAXL), .FIXED_PRIORITY(1)) f_dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_valid(f_v0), .i_m0_byte_address(32'h0), .i_m0_write_data(32'h0),
        .i_m0_write_enable(1'b0), .i_m0_lock(1'b0), .o_m0_ready(f_ready0),
        .o_m0_rsp_valid(f_rsp_v0), .o_m0_rsp_data(f_rsp_d0),
        .i_m1_valid(f_v1), .i_m1_byte_address(32'h0), .i_m1_write_data(32'h0),
        .i_m1_write_enable(1'b0), .i_m1_lock(1'b0), .o_m1_ready(f_ready1),
        .o_m1_rsp_valid(f_rsp_v1), .o_m1_rsp_data(f_rsp_d1),
        .o_mem_enable(f_mem_en), .o_mem_byte_address(f_mem_addr), .o_mem_write_data(f_mem_wdata),
        .o_mem_write_enable(f_mem_we), .i_mem_read_data(32'h0), .o_lock_timeout(f_to)
    );

    // BRAM behaviour: registered output, write-first.
    logic [DW-1:0] ram     [0:63];
    logic [DW-1:0] ref_mem [0:63];
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_we) begin
                ram[mem_addr[7:2]] <= mem_wdata;
                mem_rdata          <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr[7:2]];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        else
            passes++;
    endtask

    // Reference model: who may use the port (owner -1 = free), whose turn it is,
    // how long the current lock has lasted, and the one response owed next cycle.
    int            owner, turn, age;
    bit            exp_rv, exp_rid;
    logic [DW-1:0] exp_rd;

    always @(negedge clk) begin
        int            win;
        bit            lk, we, to;
        logic [DW-1:0] a, d;
        if (rst) begin
            chk("reset_outputs_zero", |{m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_data,
                m1_rsp_data, mem_enable, mem_addr, mem_wdata, mem_we, lock_timeout}, 0);
            owner = -1; turn = 0; age = 0; exp_rv = 0;
        end else begin
            win = -1;
            if (owner < 0) begin
                if (m0_valid && m1_valid) win = (FP != 0) ? 0 : turn;
                else if (m0_valid)        win = 0;
                else if (m1_valid)        win = 1;
            end else if ((owner == 0 && m0_valid) || (owner == 1 && m1_valid)) begin
                win = owner;
            end
            a  = (win == 0) ? m0_addr  : (win == 1) ? m1_addr  : '0;
            d  = (win == 0) ? m0_wdata : (win == 1) ? m1_wdata : '0;
            we = (win == 0) ? m0_we    : (win == 1) ? m1_we    : 1'b0;
            lk = (win == 0) ? m0_lock  : (win == 1) ? m1_lock  : 1'b0;
            to = (owner >= 0) && (age == MAXL - 1) && !(win == owner && !lk);

            chk("m0_ready", m0_ready, win == 0);
            chk("m1_ready", m1_ready, win == 1);
            chk("mem_enable", mem_enable, win >= 0);
            chk("mem_addr", mem_addr, a);
            chk("mem_wdata", mem_wdata, d);
            chk("mem_we", mem_we, we);
            chk("lock_timeout", lock_timeout, to);
            chk("m0_rsp_valid", m0_rsp_valid, exp_rv && !exp_rid);
            chk("m1_rsp_valid", m1_rsp_valid, exp_rv && exp_rid);
            chk("m0_rsp_data", m0_rsp_data, (exp_rv && !exp_rid) ? exp_rd : '0);
            chk("m1_rsp_data", m1_rsp_data, (exp_rv && exp_rid) ? exp_rd : '0);

            exp_rv  = (win >= 0);
            exp_rid = (win == 1);
            if (win >= 0) begin
                exp_rd = we ? d : ref_mem[a[7:2]];
                if (we) ref_mem[a[7:2]] = d;
            end
            if (owner < 0) begin
                if (win >= 0) begin
                    turn = 1 - win;
                    if (lk) begin owner = win; age = 0; end
                end
            end else if (to || (win == owner && !lk)) begin
                turn  = 1 - owner;
                owner = -1;
            end else begin
                age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] d,
                        input logic we, input logic lk);
        m0_valid = v; m0_addr = a; m0_wdata = d; m0_we = we; m0_lock = lk;
    endtask

    task automatic set1(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] d,
                        input logic we, input logic lk);
        m1_valid = v; m1_addr = a; m1_wdata = d; m1_we = we; m1_lock = lk;
    endtask

    task automatic gen(output logic v, output logic [DW-1:0] a, output logic [DW-1:0] d,
                       output logic we, output logic lk);
        v  = ($urandom_range(0, 99) < 55);
        a  = 32'($urandom_range(0, 63)) << 2;
        d  = $urandom;
        we = 1'($urandom_range(0, 1));
        lk = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        bit a0, a1;
        for (int i = 0; i < 64; i++) begin
            ram[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        ram[4]     = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        mem_rdata  = '0;
        set0(1, 32'h10, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        f_v0 = 0; f_v1 = 0;

        // Reset holds ready low even with a valid request present.
        repeat (3) begin
            @(negedge clk);
            chk("rst_m0_ready", m0_ready, 0);
            chk("rst_mem_enable", mem_enable, 0);
        end
        tick();
        rst = 0;
        set0(0, 0, 0, 0, 0);
        tick();

        // Contention: round-robin alternates, fixed priority always picks M0.
        set0(1, 32'h0, 0, 0, 0); set1(1, 32'h4, 0, 0, 0);
        f_v0 = 1; f_v1 = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
                f_v0 = 0; f_v1 = 0;
            end
            @(negedge clk);
            if (k < 4) begin
                chk("cont_m0_ready", m0_ready, (k % 2) == 0);
                chk("cont_m1_ready", m1_ready, (k % 2) == 1);
                chk("fixed_m0_ready", f_ready0, 1);
                chk("fixed_m1_ready", f_ready1, 0);
                chk("fixed_mem_en", f_mem_en, 1);
            end
            if (k > 0) begin
                chk("cont_m1_rsp", m1_rsp_valid, ((k - 1) % 2) == 1);
                chk("fixed_m0_rsp", f_rsp_v0, 1);
            end
            tick();
        end
        chk("fixed_misc_zero", |{f_rsp_v1, f_rsp_d0, f_rsp_d1, f_mem_addr, f_mem_wdata, f_mem_we, f_to}, 0);

        // Single read of an initialised word.
        set0(1, 32'h10, 0, 0, 0);
        @(negedge clk);
        chk("rd_m0_ready", m0_ready, 1);
        chk("rd_mem_enable", mem_enable, 1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        tick();
        set0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rd_rsp_valid", m0_rsp_valid, 1);
        chk("rd_rsp_data", m0_rsp_data, 32'hDEADBEEF);
        tick();

        // Write echo, then read back through the other requester.
        set1(1, 32'h40, 32'hCAFE0001, 1, 0);
        @(negedge clk);
        chk("we_m1_ready", m1_ready, 1);
        tick();
        set1(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("we_rsp_valid", m1_rsp_valid, 1);
        chk("we_rsp_data", m1_rsp_data, 32'hCAFE0001);
        tick();
        set0(1, 32'h40, 0, 0, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("we_readback", m0_rsp_data, 32'hCAFE0001);
        tick();

        // Atomic read-modify-write: M1 is shut out until the unlocking write.
        set0(1, 32'h20, 0, 0, 1);
        @(negedge clk);
        chk("rmw_lock_ready", m0_ready, 1);
        tick();
        set0(0, 0, 0, 0, 0); set1(1, 32'h80, 32'h11, 1, 0);
        @(negedge clk);
        chk("rmw_m1_blocked", m1_ready, 0);
        chk("rmw_read_data", m0_rsp_data, 32'h1000_0008);
        tick();
        set0(1, 32'h20, 32'h5, 1, 0);
        @(negedge clk);
        chk("rmw_write_ready", m0_ready, 1);
        chk("rmw_m1_still_blocked", m1_ready, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rmw_m1_granted", m1_ready, 1);
        chk("rmw_write_echo", m0_rsp_data, 32'h5);
        tick();
        set1(0, 0, 0, 0, 0);

        // Lock timeout: M1 locks and goes quiet while M0 waits.
        set1(1, 32'h30, 0, 0, 1);
        @(negedge clk);
        chk("to_m1_lock_ready", m1_ready, 1);
        tick();
        set1(0, 0, 0, 0, 0); set0(1, 32'h34, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("to_pulse", lock_timeout, k == 4);
            chk("to_m0_ready", m0_ready, k == 5);
            tick();
        end
        set0(0, 0, 0, 0, 0);

        // Reset during a lock with a response in flight.
        set0(1, 32'h50, 0, 0, 1);
        tick();
        set0(1, 32'h54, 0, 0, 1);
        @(negedge clk);
        chk("rml_locked_ready", m0_ready, 1);
        tick();
        rst = 1;
        set1(1, 32'h58, 0, 0, 0);
        @(negedge clk);
        chk("rml_rsp_dropped", m0_rsp_valid, 0);
        chk("rml_ready_low", m0_ready | m1_ready, 0);
        chk("rml_mem_enable", mem_enable, 0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("rml_no_late_rsp", m0_rsp_valid, 0);
        chk("rml_m0_first", m0_ready, 1);
        chk("rml_m1_waits", m1_ready, 0);
        tick();

        // Random traffic obeying hold-until-accepted, with occasional resets.
        repeat (3000) begin
            @(negedge clk);
            a0 = m0_valid & m0_ready;
            a1 = m1_valid & m1_ready;
            tick();
            if (rst) rst = 0;
            else if ($urandom_range(0, 399) == 0) rst = 1;
            if (!(m0_valid && !a0)) gen(m0_valid, m0_addr, m0_wdata, m0_we, m0_lock);
            if (!(m1_valid && !a1)) gen(m1_valid, m1_addr, m1_wdata, m1_we, m1_lock);
        end
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
